sobel_edge_stage: RTL
=====================

# sobel_edge_stage

Downstream consumer of the three-row pixel fetcher in the edge-detection pipeline. Accepts one vertical column (top/middle/bottom pixel) per strobe and shifts it into a 3×3 window. Computes the Sobel gradient magnitude of the window through a two-stage pipeline and emits one 8-bit edge pixel per column once three columns of the current row are loaded. Output feeds the result-image writer.

## Interface
- `THRESH`, default 8'd64: binarisation threshold. Used only when `SOBEL_THRESHOLD_EN` is defined.
- `subClk`, input, 1: pipeline clock, rising edge.
- `rstN`, input, 1: reset, asynchronous, active-low.
- `top`, input, 8: pixel at row p−w of the incoming column.
- `middle`, input, 8: pixel at row p of the incoming column.
- `bottom`, input, 8: pixel at row p+w of the incoming column.
- `colValid`, input, 1: the column on top/middle/bottom is complete; sampled once per high cycle.
- `lineStart`, input, 1: the current column (if any) is the first of a new row; the window is cleared.
- `edgeOut`, output, 8: edge magnitude (or 0/255 in threshold mode).
- `edgeValid`, output, 1: single-cycle strobe qualifying `edgeOut`.
- `windowFull`, output, 1: high while the window holds three valid columns (state FULL).

## Operation
- Window registers: columns c0 (left, oldest), c1, c2 (right, newest), each holding t/m/b. On `colValid`: c0←c1, c1←c2, c2←{top,middle,bottom}.
- Fill FSM states: EMPTY, ONE, TWO, FULL.
  - On `colValid`: EMPTY→ONE→TWO→FULL. FULL stays FULL.
  - `lineStart` without `colValid`: any state→EMPTY; window zeroed.
  - `lineStart` with `colValid`: window zeroed except c2 = the new column; state→ONE.
  - With neither strobe, the state holds.
- A column produces a result when, after accepting it, the state is FULL. The first two columns of each row produce nothing.
- Stage 1 (gradients, signed 11-bit):
  - Gx = (c2t + 2·c2m + c2b) − (c0t + 2·c0m + c0b)
  - Gy = (c0b + 2·c1b + c2b) − (c0t + 2·c1t + c2t)
  - Range of each is ±1020. Intermediate sums are 10-bit unsigned and are zero-extended before subtraction.
- Stage 2: mag = |Gx| + |Gy|, 11-bit unsigned, maximum 2040. `edgeOut` = mag saturated to 255.
- A valid bit travels alongside each stage. Bubbles are allowed; back-to-back `colValid` on every cycle is supported at full rate.
- `lineStart` does not flush the pipeline. Results already in stages 1/2 still emerge.
- `top`, `middle` and `bottom` are ignored while `colValid` is low.

## Timing
- Column sampled at rising edge E:
  - Window and state update at E.
  - Stage-1 registers update at E+1.
  - `edgeOut` and `edgeValid` update at E+2.
- Latency: 2 cycles from the column-accept edge to the output edge.
- `edgeValid` is high for exactly one cycle per qualifying column. `edgeOut` holds its last value when `edgeValid` is low.
- Reset (`rstN` low, asynchronous, at any time including mid-pipeline):
  - State→EMPTY; window, gradients and valid bits→0.
  - `edgeOut`=0, `edgeValid`=0, `windowFull`=0.
  - Recovery is synchronous. The first edge with `rstN` high may accept a column.
- `windowFull` is registered. It is high from the edge after the third column of a row is accepted until `lineStart` or reset.

## Configuration
- `SOBEL_THRESHOLD_EN` defined: stage 2 outputs `edgeOut` = 8'd255 if mag ≥ THRESH (zero-extended to 11 bits), else 8'd0. Latency is unchanged.
- `SOBEL_THRESHOLD_EN` undefined: `edgeOut` = min(mag, 255). `THRESH` is unused.

## Test plan
- Reset, then `lineStart`+`colValid` followed by 4 columns of all-100 → no `edgeValid` for columns 1–2; then three strobes with `edgeOut`=0, each 2 cycles after its column.
- Columns (0,0,0), (0,0,0), (255,255,255) after `lineStart` → Gx=1020, Gy=0; `edgeOut`=255 in both modes.
- Columns (10,10,10), (10,10,10), (20,20,20) → mag=40; `edgeOut`=40 without the macro; with the macro and THRESH=64, `edgeOut`=0; repeat with THRESH=40 → 255.
- Three identical columns (0,0,50) → Gy=200; `edgeOut`=200 without the macro.
- Back-to-back `colValid` for 6 cycles, then `lineStart` with `colValid` on cycle 7 → 4 results at full rate, in-flight results still delivered; new row gives no `edgeValid` until its third column; `windowFull` drops the edge after `lineStart`.
- Assert `rstN` low asynchronously between E and E+2 of a qualifying column → `edgeValid` never pulses for it; all outputs 0 immediately; a normal fill works after release.

Source files
------------

// File: rtl/sobel_edge_stage.sv
// sobel_edge_stage: 3x3 Sobel edge stage fed one pixel column per strobe.
// A fill FSM tracks how many columns of the current row are in the window.
// A two-stage pipeline computes |Gx| + |Gy|.
// Optional build macro: SOBEL_THRESHOLD_EN. When it is defined, the output is
// binarised against THRESH (0 or 255) instead of being saturated to 255.
module sobel_edge_stage #(
    parameter logic [7:0] THRESH = 8'd64
) (
    input  logic       subClk,
    input  logic       rstN,
    input  logic [7:0] top,
    input  logic [7:0] middle,
    input  logic [7:0] bottom,
    input  logic       colValid,
    input  logic       lineStart,
    output logic [7:0] edgeOut,
    output logic       edgeValid,
    output logic       windowFull
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        FULL  = 2'd3
    } fillState_e;

    fillState_e state_q, state_d;

    // Window columns packed as {top, middle, bottom}; c0 is oldest, c2 newest
    logic [23:0] c0_q, c1_q, c2_q;
    logic [23:0] c0_d, c1_d, c2_d;

    // Marks that the window now holds a column that must produce a result
    logic        winValid_q, winValid_d;
    logic        windowFull_q, windowFull_d;

    logic [10:0] gx_q, gy_q;
    logic [10:0] gx_d, gy_d;
    logic        s1Valid_q;

    logic [7:0]  edgeOut_q, edgeOut_d;
    logic        edgeValid_q;

    logic [9:0]  sumRight, sumLeft, sumBottom, sumTop;
    logic [9:0]  absX, absY;
    logic [10:0] mag;

    // Fill state register
    always_ff @(posedge subClk or negedge rstN) begin
        if (!rstN) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next fill state: a new row restarts the count, otherwise columns advance it
    always_comb begin
        state_d = state_q;
        if (lineStart) begin
            state_d = colValid ? ONE : EMPTY;
        end else if (colValid) begin
            case (state_q)
                EMPTY:   state_d = ONE;
                ONE:     state_d = TWO;
                TWO:     state_d = FULL;
                default: state_d = FULL;
            endcase
        end
    end

    // Window load/clear, result qualification and full flag derived from the FSM
    always_comb begin
        c0_d         = c0_q;
        c1_d         = c1_q;
        c2_d         = c2_q;
        winValid_d   = colValid && (state_d == FULL);
        windowFull_d = (state_d == FULL);
        if (lineStart) begin
            c0_d = 24'd0;
            c1_d = 24'd0;
            c2_d = colValid ? {top, middle, bottom} : 24'd0;
        end else if (colValid) begin
            c0_d = c1_q;
            c1_d = c2_q;
            c2_d = {top, middle, bottom};
        end
    end

    // Window registers and the window-stage valid bit
    always_ff @(posedge subClk or negedge rstN) begin
        if (!rstN) begin
            c0_q         <= 24'd0;
            c1_q         <= 24'd0;
            c2_q         <= 24'd0;
            winValid_q   <= 1'b0;
            windowFull_q <= 1'b0;
        end else begin
            c0_q         <= c0_d;
            c1_q         <= c1_d;
            c2_q         <= c2_d;
            winValid_q   <= winValid_d;
            windowFull_q <= windowFull_d;
        end
    end

    // Weighted column/row sums; each fits in 10 bits (max 1020)
    always_comb begin
        sumRight  = {2'b00, c2_q[23:16]} + {1'b0, c2_q[15:8], 1'b0} + {2'b00, c2_q[7:0]};
        sumLeft   = {2'b00, c0_q[23:16]} + {1'b0, c0_q[15:8], 1'b0} + {2'b00, c0_q[7:0]};
        sumBottom = {2'b00, c0_q[7:0]}   + {1'b0, c1_q[7:0], 1'b0}  + {2'b00, c2_q[7:0]};
        sumTop    = {2'b00, c0_q[23:16]} + {1'b0, c1_q[23:16], 1'b0} + {2'b00, c2_q[23:16]};
        gx_d      = {1'b0, sumRight}  - {1'b0, sumLeft};
        gy_d      = {1'b0, sumBottom} - {1'b0, sumTop};
    end

    // Stage 1: register the two's-complement gradients with their valid bit
    always_ff @(posedge subClk or negedge rstN) begin
        if (!rstN) begin
            gx_q      <= 11'd0;
            gy_q      <= 11'd0;
            s1Valid_q <= 1'b0;
        end else begin
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            s1Valid_q <= winValid_q;
        end
    end

    // Magnitude |Gx|+|Gy| and the final output mapping
    always_comb begin
        absX = gx_q[10] ? (~gx_q[9:0] + 10'd1) : gx_q[9:0];
        absY = gy_q[10] ? (~gy_q[9:0] + 10'd1) : gy_q[9:0];
        mag  = {1'b0, absX} + {1'b0, absY};
`ifdef SOBEL_THRESHOLD_EN
        edgeOut_d = (mag >= {3'b000, THRESH}) ? 8'd255 : 8'd0;
`else
        edgeOut_d = (mag > 11'd255) ? 8'd255 : mag[7:0];
`endif
    end

`ifndef SOBEL_THRESHOLD_EN
    logic unusedThresh;
    assign unusedThresh = ^THRESH;
`endif

    // Stage 2: output pixel updates only on a valid result and holds otherwise
    always_ff @(posedge subClk or negedge rstN) begin
        if (!rstN) begin
            edgeOut_q   <= 8'd0;
            edgeValid_q <= 1'b0;
        end else begin
            edgeValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                edgeOut_q <= edgeOut_d;
            end
        end
    end

    assign edgeOut    = edgeOut_q;
    assign edgeValid  = edgeValid_q;
    assign windowFull = windowFull_q;

endmodule
